// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync/RGB output stage and frame-rate move pulse
module vga_timing_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BACK    = 64,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 23,
    parameter bit SYNC_POL  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [3:0]  tick_div,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    output logic [10:0] X,
    output logic [10:0] Y,
    output logic        video_on,
    output logic        move_en,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS     = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS     = 11'(V_VISIBLE);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE - 1);
    localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic        move_en_q, move_en_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [11:0] rgb_q, rgb_d;

    logic        vis;
    logic        hs0;
    logic        vs0;
    logic        line_end;
    logic        frame_bnd;

    always_comb begin
        vis       = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        hs0       = ((hcnt_q >= HS_START) && (hcnt_q <= HS_END)) ? SYNC_POL : !SYNC_POL;
        vs0       = ((vcnt_q >= VS_START) && (vcnt_q <= VS_END)) ? SYNC_POL : !SYNC_POL;
        line_end  = (hcnt_q == H_LAST);
        frame_bnd = line_end && (vcnt_q == V_VIS_END);

        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        fcnt_d    = fcnt_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        rgb_d     = rgb_q;
        move_en_d = 1'b0;

        if (pix_en) begin
            hsync_d = hs0;
            vsync_d = vs0;
            rgb_d   = vis ? {red_in, green_in, blue_in} : 12'h000;

            if (line_end) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? 11'd0 : vcnt_q + 11'd1;
            end else begin
                hcnt_d = hcnt_q + 11'd1;
            end

            // Pulse lands on the first blanking pixel so sprites only move off-screen.
            if (frame_bnd) begin
                if (fcnt_q >= tick_div) begin
                    move_en_d = 1'b1;
                    fcnt_d    = '0;
                end else begin
                    fcnt_d = fcnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            fcnt_q    <= '0;
            move_en_q <= 1'b0;
            hsync_q   <= !SYNC_POL;
            vsync_q   <= !SYNC_POL;
            rgb_q     <= '0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            fcnt_q    <= fcnt_d;
            move_en_q <= move_en_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            rgb_q     <= rgb_d;
        end
    end

    assign X        = hcnt_q;
    assign Y        = vcnt_q;
    assign video_on = vis;
    assign move_en  = move_en_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign red      = rgb_q[11:8];
    assign green    = rgb_q[7:4];
    assign blue     = rgb_q[3:0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6, VF = 2, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam bit POL = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b1;
    logic [3:0]  tick_div = 4'd0;
    logic [3:0]  red_in = 4'd0, green_in = 4'd0, blue_in = 4'd0;
    logic [10:0] X, Y;
    logic        video_on, move_en, hsync, vsync;
    logic [3:0]  red, green, blue;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: linear pixel index within the frame plus the stage-1 outputs.
    int          m_p = 0;
    int          m_cnt = 0;
    logic        m_hs = !POL, m_vs = !POL, m_mv = 1'b0;
    logic [11:0] m_rgb = 12'h000;

    typedef struct {
        logic        rst;
        logic        pen;
        logic [11:0] rgb;
        int          ex, ey, evid, ehs;
        logic [11:0] ergb;
    } vec_t;
    vec_t vecs[8];

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(POL)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .tick_div(tick_div),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .X(X), .Y(Y), .video_on(video_on), .move_en(move_en),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int xh, yv;
        xh = m_p % HT;
        yv = m_p / HT;
        if (reset) begin
            m_p = 0; m_cnt = 0; m_mv = 1'b0;
            m_hs = !POL; m_vs = !POL; m_rgb = 12'h000;
        end else if (pix_en) begin
            m_hs  = (xh >= HV + HF && xh < HV + HF + HS) ? POL : !POL;
            m_vs  = (yv >= VV + VF && yv < VV + VF + VS) ? POL : !POL;
            m_rgb = (xh < HV && yv < VV) ? {red_in, green_in, blue_in} : 12'h000;
            m_mv  = 1'b0;
            if (xh == HT - 1 && yv == VV - 1) begin
                if (m_cnt >= int'(tick_div)) begin
                    m_mv = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            m_p = (m_p + 1) % FRAME;
        end else begin
            m_mv = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic pe, input logic [11:0] rgb);
        reset = r;
        pix_en = pe;
        {red_in, green_in, blue_in} = rgb;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("X", int'(X), m_p % HT);
        chk("Y", int'(Y), m_p / HT);
        chk("video_on", int'(video_on), int'((m_p % HT) < HV && (m_p / HT) < VV));
        chk("hsync", int'(hsync), int'(m_hs));
        chk("vsync", int'(vsync), int'(m_vs));
        chk("rgb", int'({red, green, blue}), int'(m_rgb));
        chk("move_en", int'(move_en), int'(m_mv));
    endtask

    initial begin
        int pulses, hs_hi, vs_hi, first_mv;
        logic prev_hs;

        vecs[0] = '{1'b1, 1'b1, 12'hFA5, 0, 0, 1, 0, 12'h000};
        vecs[1] = '{1'b1, 1'b1, 12'hFA5, 0, 0, 1, 0, 12'h000};
        vecs[2] = '{1'b1, 1'b1, 12'hFA5, 0, 0, 1, 0, 12'h000};
        vecs[3] = '{1'b0, 1'b1, 12'hFA5, 1, 0, 1, 0, 12'hFA5};
        vecs[4] = '{1'b0, 1'b0, 12'h123, 1, 0, 1, 0, 12'hFA5};
        vecs[5] = '{1'b0, 1'b0, 12'h456, 1, 0, 1, 0, 12'hFA5};
        vecs[6] = '{1'b0, 1'b1, 12'h123, 2, 0, 1, 0, 12'h123};
        vecs[7] = '{1'b0, 1'b1, 12'hABC, 3, 0, 1, 0, 12'hABC};

        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].rst, vecs[i].pen, vecs[i].rgb);
            chk("vec_x", int'(X), vecs[i].ex);
            chk("vec_y", int'(Y), vecs[i].ey);
            chk("vec_vid", int'(video_on), vecs[i].evid);
            chk("vec_hs", int'(hsync), vecs[i].ehs);
            chk("vec_rgb", int'({red, green, blue}), int'(vecs[i].ergb));
        end

        // One frame at tick_div=0: sync widths, hsync rise position, one pulse.
        step(1'b1, 1'b1, 12'hFA5);
        pulses = 0; hs_hi = 0; vs_hi = 0; prev_hs = hsync;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 1'b1, 12'hFA5);
            if (hsync && !prev_hs) chk("hs_rise_x", int'(X), HV + HF + 1);
            prev_hs = hsync;
            hs_hi += int'(hsync);
            vs_hi += int'(vsync);
            pulses += int'(move_en);
        end
        chk("hs_high_per_frame", hs_hi, HS * VT);
        chk("vs_high_per_frame", vs_hi, VS * HT);
        chk("pulses_div0", pulses, 1);
        chk("wrap_x", int'(X), 0);
        chk("wrap_y", int'(Y), 0);

        // tick_div=2 over 7 frames: pulses on frames 3 and 6 at (0, VV).
        tick_div = 4'd2;
        step(1'b1, 1'b1, 12'h000);
        pulses = 0;
        for (int i = 0; i < 7 * FRAME; i++) begin
            step(1'b0, 1'b1, 12'(i));
            if (move_en) begin
                pulses++;
                chk("mv_x", int'(X), 0);
                chk("mv_y", int'(Y), VV);
            end
        end
        chk("pulses_div2", pulses, 2);

        // Stall straddling the frame boundary suppresses the pulse until it resumes.
        tick_div = 4'd0;
        step(1'b1, 1'b1, 12'h000);
        for (int i = 0; i < VV * HT - 1; i++) step(1'b0, 1'b1, 12'h777);
        step(1'b0, 1'b0, 12'h777);
        chk("stall_no_mv", int'(move_en), 0);
        step(1'b0, 1'b0, 12'h777);
        chk("stall_hold_x", int'(X), HT - 1);
        step(1'b0, 1'b1, 12'h777);
        chk("stall_mv", int'(move_en), 1);

        // Mid-frame reset at (5,3) with the frame counter at 1.
        tick_div = 4'd1;
        step(1'b1, 1'b1, 12'h000);
        for (int i = 0; i < FRAME + 3 * HT + 5; i++) step(1'b0, 1'b1, 12'h3C3);
        chk("pre_rst_x", int'(X), 5);
        chk("pre_rst_y", int'(Y), 3);
        step(1'b1, 1'b1, 12'h3C3);
        chk("rst_x", int'(X), 0);
        chk("rst_y", int'(Y), 0);
        chk("rst_rgb", int'({red, green, blue}), 0);
        chk("rst_hs", int'(hsync), int'(!POL));
        chk("rst_vs", int'(vsync), int'(!POL));
        first_mv = -1;
        for (int i = 1; i <= 3 * FRAME && first_mv < 0; i++) begin
            step(1'b0, 1'b1, 12'h3C3);
            if (move_en) first_mv = i;
        end
        chk("first_mv_after_rst", first_mv, FRAME + VV * HT);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) tick_div = 4'($urandom_range(0, 3));
            step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, 12'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream timing stage for the 800x600 sprite pipeline.
- Generates the raster pixel coordinates X/Y that every sprite widget compares against, and the once-per-N-frames move_en pulse that drives each widget's enable.
- Takes the composited pixel colour back in, blanks it outside the visible area, and registers it.
- Drives hsync, vsync and RGB to the VGA connector with all three mutually aligned.
- Default timing: 800x600 @ 72 Hz, 50 MHz pixel rate.

Parameters:
- H_VISIBLE, 800, visible pixels per line
- H_FRONT, 56, horizontal front porch, pixels
- H_SYNC, 120, horizontal sync width, pixels
- H_BACK, 64, horizontal back porch, pixels
- V_VISIBLE, 600, visible lines per frame
- V_FRONT, 37, vertical front porch, lines
- V_SYNC, 6, vertical sync width, lines
- V_BACK, 23, vertical back porch, lines
- SYNC_POL, 1, active level of hsync/vsync (1 = active-high)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pix_en  in  1  pixel-rate clock enable; tie to 1 when clk is the 50 MHz pixel clock
- tick_div  in  4  frames per move_en pulse, minus one
- red_in, green_in, blue_in  in  4 each  composited colour for the current X/Y
- X  out  11  current horizontal count, 0..H_TOTAL-1
- Y  out  11  current vertical count, 0..V_TOTAL-1
- video_on  out  1  high when X<H_VISIBLE and Y<V_VISIBLE
- move_en  out  1  one-clk pulse; drives sprite enable
- hsync, vsync  out  1 each  registered sync outputs
- red, green, blue  out  4 each  registered, blanked colour

Behaviour:
- Derived totals:
  - H_TOTAL = sum of the four H_* parameters (1040 by default).
  - V_TOTAL = sum of the four V_* parameters (666 by default).
- Counters hcnt and vcnt are 11-bit unsigned registers and drive X and Y directly (stage 0).
- Counter stepping, on a clk edge with pix_en=1:
  - hcnt increments.
  - When hcnt=H_TOTAL-1, hcnt wraps to 0 and vcnt increments.
  - When vcnt=V_TOTAL-1 and hcnt=H_TOTAL-1, both counters wrap to 0.
- pix_en=0: every register holds and move_en is 0.
- video_on is combinational from the stage-0 counters.
- Sync windows (stage 0):
  - hs0 is active when H_VISIBLE+H_FRONT <= hcnt <= H_VISIBLE+H_FRONT+H_SYNC-1, i.e. 856..975 by default.
  - vs0 is active when V_VISIBLE+V_FRONT <= vcnt <= V_VISIBLE+V_FRONT+V_SYNC-1, i.e. 637..642 by default.
  - "Active" means equal to SYNC_POL.
- Output stage (stage 1, one pix_en cycle of latency):
  - hsync <= hs0 and vsync <= vs0.
  - {red,green,blue} <= video_on ? {red_in,green_in,blue_in} : 12'h000.
  - Widget colour and hit logic is combinational from X/Y, so the colour inputs belong to the same cycle as the current X/Y. Sync and RGB therefore leave the block aligned.
- Frame divider:
  - fcnt is a 4-bit register.
  - A frame boundary is the pix_en cycle in which hcnt=H_TOTAL-1 and vcnt=V_VISIBLE-1, i.e. the last visible pixel.
  - At a frame boundary:
    - If fcnt >= tick_div: move_en=1 for that clk and fcnt <= 0.
    - Otherwise: fcnt <= fcnt+1.
  - move_en is registered and is high on the first vertical-blank cycle (X=0, Y=V_VISIBLE). Sprite positions therefore update during blanking only.
- tick_div is sampled at each frame boundary; changing it takes effect immediately.
  - If tick_div drops below the current fcnt, the >= compare fires at the next boundary. There is no lockout.
- Reset values:
  - hcnt=0, vcnt=0, fcnt=0, move_en=0.
  - hsync=vsync=!SYNC_POL.
  - red=green=blue=0.
- Reset asserted mid-frame behaves identically to reset from idle. Reset has priority over pix_en.
- There is no other state.

Test Plan:
- Reset: hold reset 3 clks with pix_en=1, then release.
  - Required: X=0, Y=0, video_on=1, hsync=vsync=0, RGB=0, move_en=0.
  - After 1 clk: X=1.
- Horizontal timing: pix_en=1, tick_div=0, red_in=F, green_in=A, blue_in=5.
  - Required: hsync rises 1 clk after X=856 and falls 1 clk after X=976; 120 clks wide; period 1040.
  - RGB reads F/A/5 1 clk after X=799 and 000 1 clk after X=800.
- Vertical timing and frame wrap.
  - Required: vsync high for exactly 6×1040 clks, starting 1 clk after (X=0, Y=637).
  - After (1039,665), X/Y return to 0/0; frame period is 692,640 clks.
- move_en rate, tick_div=2: run 7 frames.
  - Required: move_en pulses exactly once per 3 frames, each time on the clk where X=0, Y=600, and is 1 clk wide.
  - With tick_div=0, it pulses every frame.
- pix_en stall: toggle pix_en 1,0,0,1 mid-line.
  - Required: X advances by 2 over the 4 clks; outputs hold during the low cycles; no move_en during a stall that straddles the boundary cycle.
- Reset mid-frame: assert reset at X=500, Y=300 with fcnt=1.
  - Required: next clk X=0, Y=0, RGB=0, syncs inactive.
  - With tick_div=1, the first move_en arrives after 2 full frames.
